// File: rtl/lexicase_selector_if.sv
// Handshake and control bundle for the lexicase selector. The DUT takes the
// slave view; the upstream evaluator / parent-selection side takes master.
interface lexicase_selector_if #(
  parameter int unsigned POP_SIZE  = 8,
  parameter int unsigned NUM_CASES = 16
);
  localparam int unsigned IdxW = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam int unsigned OffW = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1;
  localparam int unsigned FitW = $clog2(NUM_CASES + 1);

  // Row load channel
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_CASES-1:0] in_hits;
  logic                 in_last;
  // Control
  logic                 clear;
  logic                 start;
  logic                 fix_en;
  logic [OffW-1:0]      fix_offset;
  logic                 busy;
  // Result channel
  logic                 sel_valid;
  logic                 sel_ready;
  logic [IdxW-1:0]      sel_index;
  logic [FitW-1:0]      sel_fitness;

  modport master (
    output in_valid, in_hits, in_last, clear, start, fix_en, fix_offset, sel_ready,
    input  in_ready, busy, sel_valid, sel_index, sel_fitness
  );

  modport slave (
    input  in_valid, in_hits, in_last, clear, start, fix_en, fix_offset, sel_ready,
    output in_ready, busy, sel_valid, sel_index, sel_fitness
  );
endinterface

// File: rtl/lexicase_selector.sv
// Lexicase parent selector. Stores up to POP_SIZE hit rows, then on each start
// walks the test cases one per cycle from a random (or forced) offset,
// narrowing the candidate set to rows that pass each case. Cases that no
// remaining candidate passes are skipped. The lowest surviving index wins.
module lexicase_selector #(
  parameter int unsigned POP_SIZE  = 8,
  parameter int unsigned NUM_CASES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  lexicase_selector_if.slave bus
);

  localparam int unsigned IdxW = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
  localparam int unsigned CntW = $clog2(POP_SIZE + 1);
  localparam int unsigned OffW = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1;
  localparam int unsigned FitW = $clog2(NUM_CASES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StReady,
    StFilter,
    StOut
  } state_e;

  state_e               r_state;
  logic [CntW-1:0]      r_count;
  logic [NUM_CASES-1:0] r_slot [POP_SIZE];
  logic [POP_SIZE-1:0]  r_cand;
  logic [OffW-1:0]      r_offset;
  logic [OffW-1:0]      r_k;
  logic [15:0]          r_lfsr;
  logic                 r_busy;
  logic                 r_sel_valid;
  logic [IdxW-1:0]      r_sel_index;
  logic [FitW-1:0]      r_sel_fitness;

  logic                 w_accept;
  logic                 w_load_done;
  logic [CntW-1:0]      w_count_inc;
  logic [15:0]          w_lfsr_next;
  logic [OffW-1:0]      w_start_offset;
  logic [OffW:0]        w_case_sum;
  logic [OffW-1:0]      w_case;
  logic [OffW-1:0]      w_bit_pos;
  logic [POP_SIZE-1:0]  w_column;
  logic [POP_SIZE-1:0]  w_pass;
  logic [POP_SIZE-1:0]  w_cand_next;
  logic [POP_SIZE-1:0]  w_init_cand;
  logic                 w_one_hot;
  logic                 w_last_case;
  logic [IdxW-1:0]      w_win;
  logic [FitW-1:0]      w_fit;

  assign bus.in_ready    = (r_state == StIdle) || (r_state == StLoad);
  assign bus.busy        = r_busy;
  assign bus.sel_valid   = r_sel_valid;
  assign bus.sel_index   = r_sel_index;
  assign bus.sel_fitness = r_sel_fitness;

  assign w_accept    = bus.in_valid && bus.in_ready && !bus.clear;
  assign w_count_inc = r_count + CntW'(1);
  assign w_load_done = bus.in_last || (w_count_inc == CntW'(POP_SIZE));

  // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);

  // Starting case for a new selection
  always_comb begin
    w_start_offset = '0;
    if (bus.fix_en) begin
      w_start_offset = bus.fix_offset;
    end else begin
      w_start_offset = OffW'(32'(r_lfsr) % NUM_CASES);
    end
  end

  // Current case index with wrap, and its bit position in a row
  always_comb begin
    w_case_sum = {1'b0, r_offset} + {1'b0, r_k};
    w_case     = '0;
    if (w_case_sum >= (OffW + 1)'(NUM_CASES)) begin
      w_case = OffW'(w_case_sum - (OffW + 1)'(NUM_CASES));
    end else begin
      w_case = OffW'(w_case_sum);
    end
    // Case j lives at bit NUM_CASES-1-j
    w_bit_pos = OffW'(NUM_CASES - 1) - w_case;
  end

  // Column of hits for the current case and the narrowed candidate set
  always_comb begin
    w_column    = '0;
    w_init_cand = '0;
    for (int i = 0; i < POP_SIZE; i++) begin
      w_column[i]    = r_slot[i][w_bit_pos];
      w_init_cand[i] = (CntW'(i) < r_count);
    end
    w_pass      = r_cand & w_column;
    w_cand_next = (|w_pass) ? w_pass : r_cand;
    w_one_hot   = (w_cand_next != '0) && ((w_cand_next & (w_cand_next - 1'b1)) == '0);
    w_last_case = (r_k == OffW'(NUM_CASES - 1));
  end

  // Lowest surviving index and the popcount of its row
  always_comb begin
    w_win = '0;
    for (int i = POP_SIZE - 1; i >= 0; i--) begin
      if (w_cand_next[i]) begin
        w_win = IdxW'(i);
      end
    end
    w_fit = '0;
    for (int b = 0; b < NUM_CASES; b++) begin
      w_fit = w_fit + FitW'(r_slot[w_win][b]);
    end
  end

  // Row storage; contents only matter below r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (rst && w_accept) begin
      r_slot[r_count[IdxW-1:0]] <= bus.in_hits;
    end
  end

  // Control FSM, LFSR and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_count       <= '0;
      r_cand        <= '0;
      r_offset      <= '0;
      r_k           <= '0;
      r_lfsr        <= LFSR_SEED;
      r_busy        <= 1'b0;
      r_sel_valid   <= 1'b0;
      r_sel_index   <= '0;
      r_sel_fitness <= '0;
    end else begin
      r_lfsr <= w_lfsr_next;
      if (bus.clear) begin
        r_state     <= StIdle;
        r_count     <= '0;
        r_cand      <= '0;
        r_busy      <= 1'b0;
        r_sel_valid <= 1'b0;
      end else begin
        case (r_state)
          StIdle, StLoad: begin
            if (w_accept) begin
              r_count <= w_count_inc;
              r_state <= w_load_done ? StReady : StLoad;
            end
          end
          StReady: begin
            if (bus.start) begin
              r_offset <= w_start_offset;
              r_cand   <= w_init_cand;
              r_k      <= '0;
              r_busy   <= 1'b1;
              r_state  <= StFilter;
            end
          end
          StFilter: begin
            r_cand <= w_cand_next;
            r_k    <= r_k + OffW'(1);
            if (w_one_hot || w_last_case) begin
              r_sel_index   <= w_win;
              r_sel_fitness <= w_fit;
              r_sel_valid   <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= StOut;
            end
          end
          StOut: begin
            if (bus.sel_ready) begin
              r_sel_valid <= 1'b0;
              r_state     <= StReady;
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
